// File: rtl/ddr3_rd_check_if.sv
// Application-side read-check bus: accepted read commands and returning read beats in,
// checker status and error statistics out.
interface ddr3_rd_check_if #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
);
    localparam int PEND_W = $clog2(FIFO_DEPTH) + 1;

    logic              rd_cmd_valid;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic              chk_clear;
    logic              chk_ready;
    logic [PEND_W-1:0] chk_pending;
    logic [31:0]       rd_count;
    logic [CNT_W-1:0]  error_num;
    logic              error_flag;
    logic [ADDR_W-1:0] err_addr;
    logic [7:0]        err_mask;
    logic              protocol_err;

    modport master (
        output rd_cmd_valid, rd_cmd_addr, app_rd_data, app_rd_data_valid, chk_clear,
        input  chk_ready, chk_pending, rd_count, error_num, error_flag, err_addr,
               err_mask, protocol_err
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_addr, app_rd_data, app_rd_data_valid, chk_clear,
        output chk_ready, chk_pending, rd_count, error_num, error_flag, err_addr,
               err_mask, protocol_err
    );
endinterface

// File: rtl/ddr3_rd_check.sv
// DDR3 read-data checker: in-order tag FIFO of read addresses, regenerates the
// address-derived pattern for each returning beat and accumulates error statistics.
module ddr3_rd_check #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic            ui_clk,
    input  logic            ui_rst_n,
    ddr3_rd_check_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [DATA_W-1:0] f_pattern(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p[32*k +: 32] = 32'(a) | (32'(k) << 28);
        end
        return p;
    endfunction

    logic [ADDR_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;
    logic [PTR_W:0]    r_pending;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_proto_evt;

    assign w_full      = r_pending[PTR_W];
    assign w_empty     = (r_pending == '0);
    assign w_push_ok   = bus.rd_cmd_valid & ~w_full;
    assign w_pop_ok    = bus.app_rd_data_valid & ~w_empty;
    assign w_proto_evt = (bus.rd_cmd_valid & w_full) | (bus.app_rd_data_valid & w_empty);

    // NOTE: tag storage and datapath pipeline registers carry no reset; validity is
    // tracked by the reset pointers and valid bits, so their power-up contents never matter.
    always_ff @(posedge ui_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[PTR_W-1:0]] <= bus.rd_cmd_addr;
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so all registers
    // sample pre-edge values; combinational processes use blocking ones.
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_pending <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_pending <= r_pending + PTR_ONE;
                2'b01:   r_pending <= r_pending - PTR_ONE;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // S1: beat data, head address and its expected pattern
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [DATA_W-1:0] r_s1_exp;
    logic [ADDR_W-1:0] r_s1_addr;

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) r_s1_valid <= 1'b0;
        else           r_s1_valid <= w_pop_ok;
    end

    always_ff @(posedge ui_clk) begin
        r_s1_data <= bus.app_rd_data;
        r_s1_addr <= r_mem[r_rptr[PTR_W-1:0]];
        r_s1_exp  <= f_pattern(r_mem[r_rptr[PTR_W-1:0]]);
    end

    // S2: per-word mismatch mask, consumed by the statistics at the next edge
    logic [7:0] w_mask;

    // NOTE: the default assignment ahead of the loop keeps this purely combinational.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < 8; k++) begin
            w_mask[k] = (r_s1_data[32*k +: 32] != r_s1_exp[32*k +: 32]);
        end
    end

    logic [31:0]       r_rd_count;
    logic [CNT_W-1:0]  r_error_num;
    logic              r_error_flag;
    logic [ADDR_W-1:0] r_err_addr;
    logic [7:0]        r_err_mask;
    logic              r_protocol_err;

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            r_rd_count     <= '0;
            r_error_num    <= '0;
            r_error_flag   <= 1'b0;
            r_err_addr     <= '0;
            r_err_mask     <= '0;
            r_protocol_err <= 1'b0;
        end else if (bus.chk_clear) begin
            r_rd_count     <= '0;
            r_error_num    <= '0;
            r_error_flag   <= 1'b0;
            r_err_addr     <= '0;
            r_err_mask     <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_proto_evt) r_protocol_err <= 1'b1;
            if (r_s1_valid) begin
                r_rd_count <= r_rd_count + 32'd1;
                if (w_mask != '0) begin
                    if (r_error_num != CNT_MAX) r_error_num <= r_error_num + CNT_ONE;
                    r_error_flag <= 1'b1;
                    // only the first erroneous beat since the last clear is recorded
                    if (!r_error_flag) begin
                        r_err_addr <= r_s1_addr;
                        r_err_mask <= w_mask;
                    end
                end
            end
        end
    end

    assign bus.chk_ready    = ~w_full;
    assign bus.chk_pending  = r_pending;
    assign bus.rd_count     = r_rd_count;
    assign bus.error_num    = r_error_num;
    assign bus.error_flag   = r_error_flag;
    assign bus.err_addr     = r_err_addr;
    assign bus.err_mask     = r_err_mask;
    assign bus.protocol_err = r_protocol_err;

endmodule
